pwm_channel_bank: RTL and testbench

- Parametrised N-channel PWM generator; successor to the fixed two-channel motor/servo controller.
- Accepts per-channel duty commands over a valid/ready interface into shadow targets.
- Applies targets glitch-free only at period boundaries, with per-period slew limiting.
- Watchdog forces all channels to a safe duty when commands stop; sits between the command decoder and motor/servo drivers.

---
 rtl/pwm_channel_bank.sv | 235 +++++++++++++++++++++++
 tb/tb_pwm_channel_bank.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_channel_bank.sv
// pwm_channel_bank
//   N-channel PWM generator with shadow duty targets, boundary-only updates,
//   per-period slew limiting and a command watchdog that parks every channel
//   at a safe duty when the command stream goes quiet.
//
// Ports
//   clk            system clock, all state on the rising edge
//   clr            asynchronous active-low reset
//   cmd_valid      command present
//   cmd_ready      command can be accepted this cycle
//   cmd_chan       target channel index (CH_W bits)
//   cmd_duty       requested duty in counter ticks (DUTY_W bits)
//   enable         output enable, low forces pwm_out to 0
//   pwm_out        registered PWM pulses, one bit per channel
//   period_tick    one-cycle pulse on the last cycle of each period
//   timeout_fault  watchdog fault flag
//   cmd_err        one-cycle pulse after an accepted command with cmd_chan >= NCH

module pwm_channel_bank #(
    parameter int NCH             = 4,
    // Derived from NCH; not meant to be overridden.
    parameter int CH_W            = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int DUTY_W          = 17,
    parameter int PERIOD          = 1000,
    parameter int PRESCALE        = 10,
    parameter int STEP            = 50,
    parameter int TIMEOUT_PERIODS = 50,
    parameter int SAFE_DUTY       = 0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CH_W-1:0]   cmd_chan,
    input  logic [DUTY_W-1:0] cmd_duty,
    input  logic              enable,
    output logic [NCH-1:0]    pwm_out,
    output logic              period_tick,
    output logic              timeout_fault,
    output logic              cmd_err
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int WD_W = (TIMEOUT_PERIODS > 0) ? $clog2(TIMEOUT_PERIODS + 1) : 1;

    localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PERIOD - 1);
    localparam logic [DUTY_W-1:0] PERIOD_V = DUTY_W'(PERIOD);

    // |target - active| never exceeds PERIOD, so clamping STEP to PERIOD keeps
    // the "no limit" behaviour while keeping the constant inside DUTY_W bits.
    localparam logic [DUTY_W-1:0] STEP_V = DUTY_W'((STEP >= PERIOD) ? PERIOD : STEP);
    localparam logic [DUTY_W-1:0] SAFE_V = DUTY_W'((SAFE_DUTY > PERIOD) ? PERIOD : SAFE_DUTY);

    localparam bit              WD_EN   = (TIMEOUT_PERIODS > 0);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_PERIODS);
    localparam logic [WD_W-1:0] WD_PRE  = WD_W'((TIMEOUT_PERIODS > 0) ? TIMEOUT_PERIODS - 1 : 0);

    localparam int unsigned NCH_U = NCH;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PS_W-1:0]   presc_q;
    logic [DUTY_W-1:0] cnt_q;
    logic              ready_en_q;
    logic [WD_W-1:0]   wd_q;
    logic              fault_q;
    logic              period_tick_q;
    logic              cmd_err_q;
    logic [NCH-1:0]    pwm_q;
    logic [DUTY_W-1:0] target_q [NCH];
    logic [DUTY_W-1:0] active_q [NCH];

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic              tick;
    logic              period_end;
    logic              accept;
    logic              chan_ok;
    logic              cmd_ok;
    logic              cmd_bad;
    logic              wd_fire;
    logic [DUTY_W-1:0] duty_clamped;

    assign tick       = (presc_q == PS_LAST);
    assign period_end = tick && (cnt_q == CNT_LAST);

    // Blocking commands in the boundary cycle keeps target writes and the
    // active update from ever landing on the same edge.
    assign cmd_ready = ready_en_q && !period_end;
    assign accept    = cmd_valid && cmd_ready;
    assign chan_ok   = (32'(cmd_chan) < NCH_U);
    assign cmd_ok    = accept && chan_ok;
    assign cmd_bad   = accept && !chan_ok;

    // The count only ever passes WD_PRE once before saturating at WD_LAST,
    // so this fires exactly once per silent stretch.
    assign wd_fire = WD_EN && period_end && (wd_q == WD_PRE);

    assign duty_clamped = (cmd_duty > PERIOD_V) ? PERIOD_V : cmd_duty;

    function automatic logic [DUTY_W-1:0] slew(input logic [DUTY_W-1:0] tgt,
                                               input logic [DUTY_W-1:0] cur);
        logic [DUTY_W-1:0] res;
        res = tgt;
        if (tgt >= cur) begin
            if ((tgt - cur) > STEP_V) begin
                res = cur + STEP_V;
            end
        end else begin
            if ((cur - tgt) > STEP_V) begin
                res = cur - STEP_V;
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Prescaler and period counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q <= '0;
        end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + DUTY_W'(1);
            end
        end
    end

    // Holds cmd_ready low while in reset and for the first cycle after it.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wd_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            if (cmd_ok) begin
                wd_q    <= '0;
                fault_q <= 1'b0;
            end else if (WD_EN && period_end && (wd_q != WD_LAST)) begin
                wd_q <= wd_q + WD_W'(1);
            end
            if (wd_fire) begin
                fault_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow targets and active duties
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NCH; i++) begin
                target_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wd_fire) begin
                    target_q[i] <= SAFE_V;
                end else if (cmd_ok && (cmd_chan == CH_W'(i))) begin
                    target_q[i] <= duty_clamped;
                end
            end
        end
    end

    // A timeout on the same boundary still ramps toward the old target; the
    // safe target takes effect from the next boundary on.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NCH; i++) begin
                active_q[i] <= '0;
            end
        end else if (period_end) begin
            for (int i = 0; i < NCH; i++) begin
                active_q[i] <= slew(target_q[i], active_q[i]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pwm_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                pwm_q[i] <= enable && (cnt_q < active_q[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            period_tick_q <= 1'b0;
            cmd_err_q     <= 1'b0;
        end else begin
            period_tick_q <= period_end;
            cmd_err_q     <= cmd_bad;
        end
    end

    assign pwm_out       = pwm_q;
    assign period_tick   = period_tick_q;
    assign timeout_fault = fault_q;
    assign cmd_err       = cmd_err_q;

endmodule

// File: tb/tb_pwm_channel_bank.sv
// tb_pwm_channel_bank
//   Three instances sharing clock, reset and command bus, each with its own
//   cmd_valid. All use PERIOD=10, PRESCALE=2 (20-clock period) so their
//   period boundaries coincide.
//     u_a: NCH=4, STEP=10, no watchdog
//     u_b: NCH=3, STEP=2,  no watchdog
//     u_c: NCH=3, STEP=2,  TIMEOUT_PERIODS=3, SAFE_DUTY=0

module tb_pwm_channel_bank;

    logic        clk;
    logic        clr;
    logic        valid_a, valid_b, valid_c;
    logic [1:0]  cmd_chan;
    logic [16:0] cmd_duty;
    logic        enable;

    logic        ready_a, ready_b, ready_c;
    logic [3:0]  pwm_a;
    logic [2:0]  pwm_b, pwm_c;
    logic        ptick_a, ptick_b, ptick_c;
    logic        fault_a, fault_b, fault_c;
    logic        err_a, err_b, err_c;

    int n_chk;
    int n_err;
    int ha [4];
    int hb [3];
    int hc [3];

    pwm_channel_bank #(.NCH(4), .DUTY_W(17), .PERIOD(10), .PRESCALE(2), .STEP(10),
                       .TIMEOUT_PERIODS(0), .SAFE_DUTY(0)) u_a (
        .clk(clk), .clr(clr), .cmd_valid(valid_a), .cmd_ready(ready_a),
        .cmd_chan(cmd_chan), .cmd_duty(cmd_duty), .enable(enable), .pwm_out(pwm_a),
        .period_tick(ptick_a), .timeout_fault(fault_a), .cmd_err(err_a));

    pwm_channel_bank #(.NCH(3), .DUTY_W(17), .PERIOD(10), .PRESCALE(2), .STEP(2),
                       .TIMEOUT_PERIODS(0), .SAFE_DUTY(0)) u_b (
        .clk(clk), .clr(clr), .cmd_valid(valid_b), .cmd_ready(ready_b),
        .cmd_chan(cmd_chan), .cmd_duty(cmd_duty), .enable(enable), .pwm_out(pwm_b),
        .period_tick(ptick_b), .timeout_fault(fault_b), .cmd_err(err_b));

    pwm_channel_bank #(.NCH(3), .DUTY_W(17), .PERIOD(10), .PRESCALE(2), .STEP(2),
                       .TIMEOUT_PERIODS(3), .SAFE_DUTY(0)) u_c (
        .clk(clk), .clr(clr), .cmd_valid(valid_c), .cmd_ready(ready_c),
        .cmd_chan(cmd_chan), .cmd_duty(cmd_duty), .enable(enable), .pwm_out(pwm_c),
        .period_tick(ptick_c), .timeout_fault(fault_c), .cmd_err(err_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [2:0] mask, input logic [1:0] ch, input int duty);
        int ok;
        ok       = 0;
        cmd_chan = ch;
        cmd_duty = 17'(duty);
        valid_a  = mask[0];
        valid_b  = mask[1];
        valid_c  = mask[2];
        for (int k = 0; k < 40 && ok == 0; k++) begin
            if (ready_a) ok = 1;
            @(negedge clk);
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
        valid_c = 1'b0;
        chk("send_accept", ok, 1);
    endtask

    // Advances to the next negedge where period_tick is high.
    task automatic sync_tick();
        int found;
        found = 0;
        for (int k = 0; k < 60 && found == 0; k++) begin
            @(negedge clk);
            if (ptick_a) found = 1;
        end
        chk("sync_tick", found, 1);
    endtask

    // Counts high clocks over the 20 clocks following a period_tick sample;
    // the window ends on the next period_tick.
    task automatic window();
        int nt;
        int last;
        nt   = 0;
        last = 0;
        for (int i = 0; i < 4; i++) ha[i] = 0;
        for (int i = 0; i < 3; i++) begin
            hb[i] = 0;
            hc[i] = 0;
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) ha[i] += int'(pwm_a[i]);
            for (int i = 0; i < 3; i++) begin
                hb[i] += int'(pwm_b[i]);
                hc[i] += int'(pwm_c[i]);
            end
            nt  += int'(ptick_a);
            last = int'(ptick_a);
        end
        chk("win_tick_count", nt, 1);
        chk("win_tick_last", last, 1);
    endtask

    // Called right after clr is released at a negedge.
    task automatic first_tick(input string tag);
        int n;
        int found;
        n     = 0;
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            @(negedge clk);
            n++;
            if (ptick_a) found = 1;
        end
        chk(tag, n, 20);
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        clr      = 1'b0;
        valid_a  = 1'b0;
        valid_b  = 1'b0;
        valid_c  = 1'b0;
        cmd_chan = '0;
        cmd_duty = '0;
        enable   = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pwm_a", int'(pwm_a), 0);
        chk("rst_pwm_c", int'(pwm_c), 0);
        chk("rst_ptick", int'(ptick_a), 0);
        chk("rst_fault_c", int'(fault_c), 0);
        chk("rst_err_b", int'(err_b), 0);
        chk("rst_ready_a", int'(ready_a), 0);
        chk("rst_ready_c", int'(ready_c), 0);
        clr = 1'b1;
        first_tick("first_tick");

        // Single write, no slew limit: 3 ticks high = 6 clocks
        send(3'b001, 2'd0, 3);
        sync_tick();
        window();
        chk("a0_duty3", ha[0], 6);
        chk("a1_idle", ha[1], 0);
        chk("a3_idle", ha[3], 0);
        window();
        chk("a0_duty3_steady", ha[0], 6);

        // Slew-limited ramp 0 -> 8 in steps of 2
        send(3'b010, 2'd1, 8);
        sync_tick();
        window();
        chk("b1_ramp2", hb[1], 4);
        window();
        chk("b1_ramp4", hb[1], 8);
        window();
        chk("b1_ramp6", hb[1], 12);
        window();
        chk("b1_ramp8", hb[1], 16);
        window();
        chk("b1_hold8", hb[1], 16);
        chk("b0_idle", hb[0], 0);

        // Out-of-range channel on 3-channel instances
        chk("c_fault_pre_err", int'(fault_c), 1);
        send(3'b110, 2'd3, 5);
        chk("err_b_pulse", int'(err_b), 1);
        chk("err_c_pulse", int'(err_c), 1);
        chk("err_a_quiet", int'(err_a), 0);
        chk("c_fault_kept", int'(fault_c), 1);
        @(negedge clk);
        chk("err_b_one_cycle", int'(err_b), 0);
        sync_tick();
        window();
        chk("b1_after_err", hb[1], 16);
        chk("b0_after_err", hb[0], 0);
        chk("b2_after_err", hb[2], 0);

        // Clamp: 15 -> 10 (constant high); then 0 must land in one step
        send(3'b001, 2'd2, 15);
        sync_tick();
        window();
        chk("a2_full", ha[2], 20);
        enable = 1'b0;
        @(negedge clk);
        chk("enable_off", int'(pwm_a), 0);
        enable = 1'b1;
        @(negedge clk);
        chk("enable_on_a2", int'(pwm_a[2]), 1);
        send(3'b001, 2'd2, 0);
        sync_tick();
        window();
        chk("a2_zero", ha[2], 0);
        chk("a0_still3", ha[0], 6);

        // Command held across a boundary
        sync_tick();
        repeat (18) @(negedge clk);
        chk("ready_before_pe", int'(ready_a), 1);
        @(negedge clk);
        chk("ready_at_pe", int'(ready_a), 0);
        cmd_chan = 2'd1;
        cmd_duty = 17'd7;
        valid_a  = 1'b1;
        @(negedge clk);
        chk("ready_after_pe", int'(ready_a), 1);
        chk("tick_after_pe", int'(ptick_a), 1);
        @(negedge clk);
        valid_a = 1'b0;
        sync_tick();
        window();
        chk("a1_held_cmd", ha[1], 14);

        // Watchdog: write ch0=5, then silence
        send(3'b100, 2'd0, 5);
        chk("c_fault_clear", int'(fault_c), 0);
        sync_tick();
        chk("c_fault_p1", int'(fault_c), 0);
        window();
        chk("c0_ramp2", hc[0], 4);
        chk("c_fault_p2", int'(fault_c), 0);
        window();
        chk("c0_ramp4", hc[0], 8);
        chk("c_fault_p3", int'(fault_c), 1);
        window();
        chk("c0_ramp5", hc[0], 10);
        window();
        chk("c0_safe3", hc[0], 6);
        window();
        chk("c0_safe1", hc[0], 2);
        window();
        chk("c0_safe0", hc[0], 0);
        chk("c_fault_held", int'(fault_c), 1);
        send(3'b100, 2'd0, 4);
        chk("c_fault_cleared", int'(fault_c), 0);

        // Reset mid-period
        sync_tick();
        repeat (3) @(negedge clk);
        chk("pre_rst_a0_high", int'(pwm_a[0]), 1);
        #2 clr = 1'b0;
        #1;
        chk("mid_rst_pwm_a", int'(pwm_a), 0);
        chk("mid_rst_pwm_c", int'(pwm_c), 0);
        chk("mid_rst_ready", int'(ready_a), 0);
        chk("mid_rst_ptick", int'(ptick_a), 0);
        @(negedge clk);
        clr = 1'b1;
        first_tick("first_tick_rerun");
        window();
        chk("post_rst_a0", ha[0], 0);
        chk("post_rst_a1", ha[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

endmodule
